// File: rtl/ic_fetch.sv
// Fetch stage: owns the PC and next-PC select, drives the instruction SRAM,
// and holds the IC pipeline register that ID latches alongside the SRAM read data.
module ic_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          ADEL_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        br_e,
  input  logic [31:0] br_addr,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [64:0] ic_to_id_bus
);

  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        br_pend;
  logic [31:0] br_tgt;
  logic [31:0] ic_exc;
  logic        ic_ce;
  logic [31:0] ic_pc;

  logic        stall_pc;
  logic        stall_ic;
  logic        stall_id;
  logic        misaligned;
  logic [31:0] fetch_exc;
  logic        unused_stall;

  assign stall_pc     = stall[0];
  assign stall_ic     = stall[1];
  assign stall_id     = stall[2];
  assign unused_stall = ^stall[5:3];

  assign misaligned = (pc_reg[1:0] != 2'b00);

  always_comb begin
    fetch_exc           = 32'b0;
    fetch_exc[ADEL_BIT] = ce_reg & misaligned;
  end

  assign inst_sram_en   = ce_reg & ~stall_pc & ~misaligned;
  assign inst_sram_wen  = 4'b0000;
  assign inst_sram_addr = pc_reg;
  assign ic_to_id_bus   = {ic_exc, ic_ce, ic_pc};

  // PC stage: a branch resolved while the PC is stalled is parked in br_tgt
  // and applied on the first unstalled edge; flush always overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg  <= RESET_PC - 32'd4;
      ce_reg  <= 1'b0;
      br_pend <= 1'b0;
      br_tgt  <= 32'b0;
    end else if (flush) begin
      pc_reg  <= new_pc;
      ce_reg  <= 1'b1;
      br_pend <= 1'b0;
    end else if (stall_pc) begin
      if (br_e) begin
        br_pend <= 1'b1;
        br_tgt  <= br_addr;
      end
    end else if (br_e) begin
      pc_reg  <= br_addr;
      ce_reg  <= 1'b1;
      br_pend <= 1'b0;
    end else if (br_pend) begin
      pc_reg  <= br_tgt;
      ce_reg  <= 1'b1;
      br_pend <= 1'b0;
    end else begin
      pc_reg  <= pc_reg + 32'd4;
      ce_reg  <= 1'b1;
    end
  end

  // IC stage: wrong-path and stale fetches are squashed to a bubble
  always_ff @(posedge clk) begin
    if (rst || flush || br_e || (br_pend && !stall_pc) || (stall_ic && !stall_id)) begin
      ic_exc <= 32'b0;
      ic_ce  <= 1'b0;
      ic_pc  <= 32'b0;
    end else if (!stall_ic) begin
      ic_exc <= fetch_exc;
      ic_ce  <= ce_reg;
      ic_pc  <= pc_reg;
    end
  end

endmodule

// File: tb/tb_ic_fetch.sv
// Directed bench for ic_fetch: reset, sequential fetch, stalls, branches,
// pending branches, flush priority, misaligned fetch, wrap and mid-run reset.
module tb_ic_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        br_e;
  logic [31:0] br_addr;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [64:0] ic_to_id_bus;

  int vecs = 0;
  int errs = 0;

  ic_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .br_e           (br_e),
    .br_addr        (br_addr),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .ic_to_id_bus   (ic_to_id_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 6'b0; flush = 1'b0; new_pc = 32'b0;
    br_e = 1'b0; br_addr = 32'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    vecs++;
    if (ic_to_id_bus !== 65'b0) begin
      errs++; $display("FAIL reset_bus got %h want %h", ic_to_id_bus, 65'b0);
    end
    vecs++;
    if (inst_sram_en !== 1'b0) begin
      errs++; $display("FAIL reset_en got %b want 0", inst_sram_en);
    end
    vecs++;
    if (inst_sram_addr !== 32'hBFBF_FFFC) begin
      errs++; $display("FAIL reset_addr got %h want BFBFFFFC", inst_sram_addr);
    end
    vecs++;
    if (inst_sram_wen !== 4'b0) begin
      errs++; $display("FAIL reset_wen got %b want 0", inst_sram_wen);
    end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hBFC0_0000; exp_pc[1] = 32'hBFC0_0004; exp_pc[2] = 32'hBFC0_0008;
    rst = 1'b0;
    tick();
    vecs++;
    if (ic_to_id_bus[32] !== 1'b0 || inst_sram_addr !== 32'hBFC0_0000 || inst_sram_en !== 1'b1) begin
      errs++; $display("FAIL seq_first ce=%b addr=%h en=%b want ce=0 addr=BFC00000 en=1",
                       ic_to_id_bus[32], inst_sram_addr, inst_sram_en);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (ic_to_id_bus !== {32'b0, 1'b1, exp_pc[i]} || inst_sram_addr !== exp_pc[i] + 32'd4) begin
        errs++; $display("FAIL seq_%0d bus=%h addr=%h want pc=%h addr=%h",
                         i, ic_to_id_bus, inst_sram_addr, exp_pc[i], exp_pc[i] + 32'd4);
      end
    end
    tick();  // pc_reg now BFC00010
  endtask

  task automatic test_stall();
    stall = 6'b000011;
    #1;
    vecs++;
    if (inst_sram_en !== 1'b0) begin
      errs++; $display("FAIL stall_en got %b want 0", inst_sram_en);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if (inst_sram_addr !== 32'hBFC0_0010 || ic_to_id_bus !== 65'b0) begin
        errs++; $display("FAIL stall_hold_%0d addr=%h bus=%h want addr=BFC00010 bus=0",
                         i, inst_sram_addr, ic_to_id_bus);
      end
    end
    stall = 6'b0;
    tick();
    vecs++;
    if (ic_to_id_bus !== {32'b0, 1'b1, 32'hBFC0_0010}) begin
      errs++; $display("FAIL stall_rel0 bus=%h want pc=BFC00010", ic_to_id_bus);
    end
    tick();
    vecs++;
    if (ic_to_id_bus !== {32'b0, 1'b1, 32'hBFC0_0014}) begin
      errs++; $display("FAIL stall_rel1 bus=%h want pc=BFC00014", ic_to_id_bus);
    end
  endtask

  task automatic test_branch();
    br_e = 1'b1; br_addr = 32'h8000_1000;
    tick();
    br_e = 1'b0;
    vecs++;
    if (inst_sram_addr !== 32'h8000_1000 || ic_to_id_bus !== 65'b0) begin
      errs++; $display("FAIL branch_redirect addr=%h bus=%h want addr=80001000 bus=0",
                       inst_sram_addr, ic_to_id_bus);
    end
    tick();
    vecs++;
    if (ic_to_id_bus !== {32'b0, 1'b1, 32'h8000_1000}) begin
      errs++; $display("FAIL branch_target bus=%h want pc=80001000", ic_to_id_bus);
    end
  endtask

  task automatic test_pending_branch();
    stall = 6'b000001; br_e = 1'b1; br_addr = 32'h8000_2000;
    tick();
    br_e = 1'b0; stall = 6'b000111;
    vecs++;
    if (inst_sram_addr !== 32'h8000_1004 || ic_to_id_bus !== 65'b0) begin
      errs++; $display("FAIL pend_capture addr=%h bus=%h want addr=80001004 bus=0",
                       inst_sram_addr, ic_to_id_bus);
    end
    tick(); tick();
    vecs++;
    if (inst_sram_addr !== 32'h8000_1004 || ic_to_id_bus !== 65'b0) begin
      errs++; $display("FAIL pend_hold addr=%h bus=%h want addr=80001004 bus=0",
                       inst_sram_addr, ic_to_id_bus);
    end
    stall = 6'b0;
    tick();
    vecs++;
    if (inst_sram_addr !== 32'h8000_2000 || ic_to_id_bus !== 65'b0) begin
      errs++; $display("FAIL pend_release addr=%h bus=%h want addr=80002000 bus=0",
                       inst_sram_addr, ic_to_id_bus);
    end
    tick();
    vecs++;
    if (ic_to_id_bus !== {32'b0, 1'b1, 32'h8000_2000}) begin
      errs++; $display("FAIL pend_target bus=%h want pc=80002000", ic_to_id_bus);
    end
  endtask

  task automatic test_flush_vs_branch();
    stall = 6'b000001; br_e = 1'b1; br_addr = 32'h8000_3000;
    tick();
    stall = 6'b0; flush = 1'b1; new_pc = 32'hBFC0_0380; br_addr = 32'h8000_4000;
    tick();
    flush = 1'b0; br_e = 1'b0;
    vecs++;
    if (inst_sram_addr !== 32'hBFC0_0380 || ic_to_id_bus !== 65'b0) begin
      errs++; $display("FAIL flush_win addr=%h bus=%h want addr=BFC00380 bus=0",
                       inst_sram_addr, ic_to_id_bus);
    end
    tick();
    vecs++;
    if (inst_sram_addr !== 32'hBFC0_0384 || ic_to_id_bus !== {32'b0, 1'b1, 32'hBFC0_0380}) begin
      errs++; $display("FAIL flush_drop_pend addr=%h bus=%h want addr=BFC00384 pc=BFC00380",
                       inst_sram_addr, ic_to_id_bus);
    end
  endtask

  task automatic test_misaligned();
    br_e = 1'b1; br_addr = 32'h8000_0002;
    tick();
    br_e = 1'b0;
    vecs++;
    if (inst_sram_en !== 1'b0 || inst_sram_addr !== 32'h8000_0002) begin
      errs++; $display("FAIL adel_en en=%b addr=%h want en=0 addr=80000002",
                       inst_sram_en, inst_sram_addr);
    end
    tick();
    vecs++;
    if (ic_to_id_bus !== {32'h0000_0010, 1'b1, 32'h8000_0002} || inst_sram_addr !== 32'h8000_0006) begin
      errs++; $display("FAIL adel_bus bus=%h addr=%h want exc=10 ce=1 pc=80000002 addr=80000006",
                       ic_to_id_bus, inst_sram_addr);
    end
    flush = 1'b1; new_pc = 32'hBFC0_0380;
    tick();
    flush = 1'b0;
    vecs++;
    if (inst_sram_en !== 1'b1 || ic_to_id_bus !== 65'b0) begin
      errs++; $display("FAIL adel_recover en=%b bus=%h want en=1 bus=0", inst_sram_en, ic_to_id_bus);
    end
    tick();
    vecs++;
    if (ic_to_id_bus !== {32'b0, 1'b1, 32'hBFC0_0380}) begin
      errs++; $display("FAIL adel_clean bus=%h want exc=0 pc=BFC00380", ic_to_id_bus);
    end
  endtask

  task automatic test_wrap();
    flush = 1'b1; new_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    tick();
    vecs++;
    if (inst_sram_addr !== 32'h0000_0000 || ic_to_id_bus !== {32'b0, 1'b1, 32'hFFFF_FFFC}) begin
      errs++; $display("FAIL wrap addr=%h bus=%h want addr=0 pc=FFFFFFFC", inst_sram_addr, ic_to_id_bus);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; stall = 6'b000111; flush = 1'b1; new_pc = 32'h1234_5678;
    br_e = 1'b1; br_addr = 32'h8765_4320;
    tick();
    vecs++;
    if (inst_sram_addr !== 32'hBFBF_FFFC || inst_sram_en !== 1'b0 || ic_to_id_bus !== 65'b0) begin
      errs++; $display("FAIL midrst addr=%h en=%b bus=%h want addr=BFBFFFFC en=0 bus=0",
                       inst_sram_addr, inst_sram_en, ic_to_id_bus);
    end
    idle_inputs();
    tick();
    vecs++;
    if (inst_sram_addr !== 32'hBFC0_0000 || inst_sram_en !== 1'b1) begin
      errs++; $display("FAIL midrst_release addr=%h en=%b want addr=BFC00000 en=1",
                       inst_sram_addr, inst_sram_en);
    end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_stall();
    test_branch();
    test_pending_branch();
    test_flush_vs_branch();
    test_misaligned();
    test_wrap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
